// File: rtl/imap_pkg.sv
// Shared definitions for the imap read scheduler: buffer geometry,
// map limits, FSM encoding and the tap/half slot counts.
package imap_pkg;

   localparam int ARRAY_NUM  = 32;
   localparam int MAX_DIM    = 56;
   localparam int BLOCK_SIZE = MAX_DIM * MAX_DIM;
   localparam int PIX_W      = 12;
   localparam int DIM_W      = 6;
   localparam int TAPS       = 9;
   localparam int HALVES     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // A map is legal when both sides are in 1..MAX_DIM.
   function automatic logic cfg_ok(input logic [DIM_W-1:0] w,
                                   input logic [DIM_W-1:0] h);
      return (w != '0) && (h != '0) &&
             (w <= DIM_W'(MAX_DIM)) && (h <= DIM_W'(MAX_DIM));
   endfunction

endpackage

// File: rtl/imap_tap_cnt.sv
// Nested oy/ox/ky/kx/half slot counter for the 3x3 convolution walk.
// Ports: clk, rst (async high), clr, en; width/height; indices out;
// first (tap 0 half 0), last (tap 8 half 1), fin (final slot of map).
module imap_tap_cnt
   import imap_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] oy,
   output logic [DIM_W-1:0] ox,
   output logic [1:0]       ky,
   output logic [1:0]       kx,
   output logic             half,
   output logic             first,
   output logic             last,
   output logic             fin
);

   logic ox_end, oy_end;

   assign ox_end = (ox == width - DIM_W'(1));
   assign oy_end = (oy == height - DIM_W'(1));
   assign first  = (ky == 2'd0) && (kx == 2'd0) && !half;
   assign last   = (ky == 2'd2) && (kx == 2'd2) && half;
   assign fin    = last && ox_end && oy_end;

   // Counters wrap to zero after the final slot, ready for the next run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oy   <= '0;
         ox   <= '0;
         ky   <= '0;
         kx   <= '0;
         half <= 1'b0;
      end else if (clr) begin
         oy   <= '0;
         ox   <= '0;
         ky   <= '0;
         kx   <= '0;
         half <= 1'b0;
      end else if (en) begin
         half <= ~half;
         if (half) begin
            if (kx == 2'd2) begin
               kx <= '0;
               if (ky == 2'd2) begin
                  ky <= '0;
                  if (ox_end) begin
                     ox <= '0;
                     oy <= oy_end ? '0 : oy + DIM_W'(1);
                  end else begin
                     ox <= ox + DIM_W'(1);
                  end
               end else begin
                  ky <= ky + 2'd1;
               end
            end else begin
               kx <= kx + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/imap_rd_sched.sv
// Input feature-map buffer controller: BIU writes while idle, 3x3 conv
// read issue while running, 1-cycle delayed valid/pad/first/last sideband.
// Ports: clk, rst; cfg_start/width/height -> busy, done, cfg_err;
// wr_* -> imap_w*; imap_ren/raddr; array_stall; dat_valid/pad/last/first.
// Macro IMAP_SCHED_PERF_EN adds perf_rd_cnt, perf_pad_cnt, perf_stall_cnt.
module imap_rd_sched
   import imap_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [DIM_W-1:0] cfg_height,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [31:0]      wr_addr,
   input  logic [63:0]      wr_data,
   output logic             imap_wen,
   output logic [31:0]      imap_waddr,
   output logic [63:0]      imap_wdata,
   output logic             imap_ren,
   output logic [31:0]      imap_raddr,
   input  logic             array_stall,
   output logic             dat_valid,
   output logic             dat_pad,
   output logic             dat_last,
   output logic             dat_first
`ifdef IMAP_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_rd_cnt,
   output logic [31:0]      perf_pad_cnt,
   output logic [31:0]      perf_stall_cnt
`endif
);

   state_t state, state_nx;

   logic             idle, run, issue, start_ok, start_bad;
   logic [DIM_W-1:0] oy, ox;
   logic [1:0]       ky, kx;
   logic             half, first, last, fin;
   logic [DIM_W:0]   sy, sx;
   logic             pad;
   logic [PIX_W-1:0] iy, ix, pix;

   assign idle      = (state == IDLE);
   assign run       = (state == RUN);
   assign issue     = run && !array_stall;
   assign start_ok  = idle && cfg_start && cfg_ok(cfg_width, cfg_height);
   assign start_bad = idle && cfg_start && !cfg_ok(cfg_width, cfg_height);

   imap_tap_cnt u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .en     (issue),
      .width  (cfg_width),
      .height (cfg_height),
      .oy     (oy),
      .ox     (ox),
      .ky     (ky),
      .kx     (kx),
      .half   (half),
      .first  (first),
      .last   (last),
      .fin    (fin)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start_ok) state_nx = RUN;
         RUN:     if (issue && fin) state_nx = DRAIN;
         DRAIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // sy/sx hold iy+1 / ix+1, so input row/col -1 shows up as zero
   // and the far edge as a value above the map size.
   assign sy  = {1'b0, oy} + {{(DIM_W-1){1'b0}}, ky};
   assign sx  = {1'b0, ox} + {{(DIM_W-1){1'b0}}, kx};
   assign pad = (sy == '0) || (sy > {1'b0, cfg_height}) ||
                (sx == '0) || (sx > {1'b0, cfg_width});
   assign iy  = PIX_W'(sy) - PIX_W'(1);
   assign ix  = PIX_W'(sx) - PIX_W'(1);
   assign pix = iy * PIX_W'(cfg_width) + ix;

   assign imap_ren   = issue && !pad;
   assign imap_raddr = imap_ren ? {19'd0, half, pix} : '0;

   assign wr_ready   = idle;
   assign imap_wen   = wr_valid && idle;
   assign imap_waddr = wr_addr;
   assign imap_wdata = wr_data;
   assign busy       = !idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_valid <= 1'b0;
         dat_pad   <= 1'b0;
         dat_first <= 1'b0;
         dat_last  <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         dat_valid <= issue;
         dat_pad   <= issue && pad;
         dat_first <= issue && first;
         dat_last  <= issue && last;
         done      <= (state == DRAIN);
         cfg_err   <= start_bad;
      end
   end

`ifdef IMAP_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_rd_cnt    <= '0;
         perf_pad_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else if (start_ok) begin
         perf_rd_cnt    <= '0;
         perf_pad_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (imap_ren && perf_rd_cnt != '1)
            perf_rd_cnt <= perf_rd_cnt + 32'd1;
         if (issue && pad && perf_pad_cnt != '1)
            perf_pad_cnt <= perf_pad_cnt + 32'd1;
         if (run && array_stall && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imap_rd_sched.sv
// Randomised self-checking bench for imap_rd_sched against a
// slot-list reference model, plus literal checks on fixed scenarios.
module tb_imap_rd_sched;

   logic        clk, rst;
   logic        cfg_start;
   logic [5:0]  cfg_width, cfg_height;
   logic        busy, done, cfg_err;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic        imap_wen, imap_ren;
   logic [31:0] imap_waddr, imap_raddr;
   logic [63:0] imap_wdata;
   logic        array_stall;
   logic        dat_valid, dat_pad, dat_last, dat_first;

   imap_rd_sched dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_start   (cfg_start),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .imap_wen    (imap_wen),
      .imap_waddr  (imap_waddr),
      .imap_wdata  (imap_wdata),
      .imap_ren    (imap_ren),
      .imap_raddr  (imap_raddr),
      .array_stall (array_stall),
      .dat_valid   (dat_valid),
      .dat_pad     (dat_pad),
      .dat_last    (dat_last),
      .dat_first   (dat_first)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state
   bit m_issuing, m_dv, m_ppad, m_pfirst, m_plast, m_pfin;
   bit m_done, m_err;
   int m_idx, m_n, m_w, m_h;

   // observations of the DUT
   int obs_dv, obs_pad, obs_ren, obs_done, obs_err;
   int obs_wen, obs_wen_busy, obs_wen_done;
   int rise_cyc, done_cyc, run_dv, run_ren;
   bit prev_busy, first_pad;
   logic [31:0] raddr0, raddr1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Slot k of a W x H run, from the nested issue order.
   task automatic slot_of(input int k, input int w, input int h,
                          output bit pad, output logic [31:0] addr,
                          output bit first, output bit last);
      int hf, kx, ky, ox, oy, iy, ix;
      hf = k % 2;
      kx = (k / 2) % 3;
      ky = (k / 6) % 3;
      ox = (k / 18) % w;
      oy = k / (18 * w);
      iy = oy + ky - 1;
      ix = ox + kx - 1;
      pad = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
      addr = pad ? 32'd0 : 32'(hf * 4096 + iy * w + ix);
      first = (k % 18) == 0;
      last = (k % 18) == 17;
      if (oy >= h) pad = 1'b1;
   endtask

   task automatic cycle_check();
      bit e_busy, s_pad, s_first, s_last, e_ren, n_done, n_err;
      logic [31:0] s_addr;
      cyc++;
      if (rst) begin
         m_issuing = 0; m_dv = 0; m_ppad = 0; m_pfirst = 0;
         m_plast = 0; m_pfin = 0; m_done = 0; m_err = 0; m_idx = 0;
      end
      s_pad = 0; s_first = 0; s_last = 0; s_addr = '0;
      if (m_issuing && !array_stall)
         slot_of(m_idx, m_w, m_h, s_pad, s_addr, s_first, s_last);
      e_busy = m_issuing || (m_dv && m_pfin);
      e_ren = m_issuing && !array_stall && !s_pad;
      chk("busy", busy, e_busy);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_err);
      chk("wr_ready", wr_ready, !e_busy);
      chk("imap_wen", imap_wen, wr_valid && !e_busy);
      chk("imap_waddr", imap_waddr, wr_addr);
      chk("imap_wdata", imap_wdata, wr_data);
      chk("imap_ren", imap_ren, e_ren);
      chk("imap_raddr", imap_raddr, e_ren ? s_addr : 32'd0);
      chk("dat_valid", dat_valid, m_dv);
      chk("dat_pad", dat_pad, m_dv && m_ppad);
      chk("dat_first", dat_first, m_dv && m_pfirst);
      chk("dat_last", dat_last, m_dv && m_plast);
      // DUT observation for scenario totals
      if (busy && !prev_busy) begin
         rise_cyc = cyc; run_dv = 0; run_ren = 0;
      end
      if (dat_valid) begin
         obs_dv++;
         if (dat_pad) obs_pad++;
         if (run_dv == 0) first_pad = dat_pad;
         run_dv++;
      end
      if (imap_ren) begin
         obs_ren++;
         if (run_ren == 0) raddr0 = imap_raddr;
         if (run_ren == 1) raddr1 = imap_raddr;
         run_ren++;
      end
      if (done) begin obs_done++; done_cyc = cyc; end
      if (cfg_err) obs_err++;
      if (imap_wen) begin
         obs_wen++;
         if (busy) obs_wen_busy++;
         if (done) obs_wen_done++;
      end
      prev_busy = busy;
      if (!rst) begin
         n_done = m_dv && m_pfin;
         n_err = 0;
         if (m_issuing && !array_stall) begin
            m_dv = 1; m_ppad = s_pad; m_pfirst = s_first;
            m_plast = s_last; m_pfin = (m_idx == m_n - 1);
            m_idx++;
            if (m_idx == m_n) m_issuing = 0;
         end else begin
            m_dv = 0; m_ppad = 0; m_pfirst = 0; m_plast = 0; m_pfin = 0;
         end
         if (!e_busy && cfg_start) begin
            if (cfg_width >= 1 && cfg_width <= 56 &&
                cfg_height >= 1 && cfg_height <= 56) begin
               m_issuing = 1; m_idx = 0;
               m_w = int'(cfg_width); m_h = int'(cfg_height);
               m_n = m_w * m_h * 18;
            end else begin
               n_err = 1;
            end
         end
         m_done = n_done;
         m_err = n_err;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int w, input int h);
      cfg_width = 6'(w);
      cfg_height = 6'(h);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string nm);
      int d0;
      d0 = obs_done;
      for (int i = 0; i < lim && obs_done == d0; i++) tick();
      chk({nm, "_done_seen"}, obs_done != d0, 1);
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim && busy; i++) tick();
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      int dv0, pad0, ren0, d0, e0, wb0, wd0, w0, np;
      bit p, f, l;
      logic [31:0] a;
      rst = 1'b1; cfg_start = 0; cfg_width = 0; cfg_height = 0;
      wr_valid = 0; wr_addr = 0; wr_data = 0; array_stall = 0;
      @(posedge clk); #1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // model pins
      np = 0;
      for (int k = 0; k < 162; k++) begin
         slot_of(k, 3, 3, p, a, f, l);
         if (!p) np++;
      end
      chk("model_3x3_reads", np, 98);
      slot_of(0, 3, 3, p, a, f, l);
      chk("model_slot0_pad", p, 1);
      slot_of(9, 3, 3, p, a, f, l);
      chk("model_slot9_addr", a, 32'h1000);

      // IDLE writes
      w0 = obs_wen;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1; wr_addr = i;
         wr_data = {$urandom, $urandom};
         tick();
      end
      wr_valid = 0;
      chk("idle_wen_beats", obs_wen - w0, 4);

      // 3x3 run, no stall
      dv0 = obs_dv; pad0 = obs_pad; ren0 = obs_ren;
      start(3, 3);
      wait_done(400, "run3x3");
      chk("run3x3_dv", obs_dv - dv0, 162);
      chk("run3x3_ren", obs_ren - ren0, 98);
      chk("run3x3_pad", obs_pad - pad0, 64);
      chk("run3x3_first_pad", first_pad, 1);
      chk("run3x3_raddr0", raddr0, 32'h0);
      chk("run3x3_raddr1", raddr1, 32'h1000);
      chk("run3x3_done_lat", done_cyc - rise_cyc, 163);
      tick();

      // 1x1 run with a 5-cycle stall
      dv0 = obs_dv; pad0 = obs_pad; ren0 = obs_ren;
      start(1, 1);
      repeat (6) tick();
      array_stall = 1;
      repeat (5) tick();
      array_stall = 0;
      wait_done(100, "stall");
      chk("stall_dv", obs_dv - dv0, 18);
      chk("stall_ren", obs_ren - ren0, 2);
      chk("stall_pad", obs_pad - pad0, 16);
      chk("stall_done_lat", done_cyc - rise_cyc, 24);
      tick();

      // write held during a run
      wb0 = obs_wen_busy; wd0 = obs_wen_done;
      wr_valid = 1; wr_addr = 32'h55; wr_data = 64'h1234;
      start(2, 2);
      wait_done(200, "arb");
      wr_valid = 0;
      chk("arb_wen_busy", obs_wen_busy - wb0, 0);
      chk("arb_wen_done", obs_wen_done - wd0, 1);
      tick();

      // illegal configs
      e0 = obs_err; ren0 = obs_ren; d0 = obs_done;
      start(0, 3); tick();
      start(57, 3); tick();
      start(3, 57); tick();
      chk("bad_err_cnt", obs_err - e0, 3);
      chk("bad_no_ren", obs_ren - ren0, 0);
      chk("bad_no_done", obs_done - d0, 0);

      // largest legal width
      dv0 = obs_dv;
      start(56, 1);
      wait_done(2000, "max_w");
      chk("max_w_dv", obs_dv - dv0, 1008);
      tick();

      // reset mid-run, then replay
      start(3, 3);
      repeat (50) tick();
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_ren", imap_ren, 0);
      chk("rst_dv", dat_valid, 0);
      chk("rst_done", done, 0);
      tick();
      rst = 1'b0;
      d0 = obs_done;
      repeat (5) tick();
      chk("rst_no_done", obs_done - d0, 0);
      dv0 = obs_dv;
      start(3, 3);
      wait_done(400, "replay");
      chk("replay_dv", obs_dv - dv0, 162);
      chk("replay_first_pad", first_pad, 1);
      chk("replay_raddr1", raddr1, 32'h1000);
      tick();

      // randomised runs
      for (int r = 0; r < 25; r++) begin
         d0 = obs_done;
         start($urandom_range(1, 5), $urandom_range(1, 5));
         for (int i = 0; i < 2000 && obs_done == d0; i++) begin
            array_stall = ($urandom % 4) == 0;
            wr_valid = $urandom % 2;
            wr_addr = $urandom;
            wr_data = {$urandom, $urandom};
            cfg_start = ($urandom % 8) == 0;
            tick();
         end
         chk("rand_done_seen", obs_done != d0, 1);
         cfg_start = 0; array_stall = 0; wr_valid = 0;
         wait_idle(3000);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imap_rd_sched.md
Name: imap_rd_sched

Overview:
- Controller in front of the 7-SRAM input feature-map buffer.
- Arbitrates the buffer between the imap BIU write stream and MAC-array reads. Writes are allowed only while idle; reads are issued only while running.
- While running, generates the 3x3 / stride-1 / pad-1 convolution read-address sequence over a W x H map. Each output pixel gets 9 taps x 2 channel halves.
- Drives a delayed valid/pad/last sideband to the MAC array, aligned with the buffer's 1-cycle read data.

Parameters:
- MAX_DIM, 56: maximum legal map width/height.
- PIX_W, 12: pixel-index address bits (MAX_DIM*MAX_DIM <= 4096).
- DIM_W, 6: width of dimension fields.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_width  in  DIM_W  map width W; held stable while busy.
- cfg_height  in  DIM_W  map height H; held stable while busy.
- busy  out  1  run in progress.
- done  out  1  single-cycle completion pulse.
- cfg_err  out  1  single-cycle pulse on an illegal start.
- wr_valid  in  1  BIU write request.
- wr_ready  out  1  write accepted.
- wr_addr  in  32  BIU write address.
- wr_data  in  64  BIU write data.
- imap_wen  out  1  buffer write enable.
- imap_waddr  out  32  buffer write address.
- imap_wdata  out  64  buffer write data.
- imap_ren  out  1  buffer read enable.
- imap_raddr  out  32  buffer read address.
- array_stall  in  1  MAC array requests no new issue.
- dat_valid  out  1  buffer read data / pad slot valid this cycle.
- dat_pad  out  1  slot is a padding tap; array uses zero.
- dat_last  out  1  final slot (tap 8, half 1) of an output pixel.
- dat_first  out  1  first slot (tap 0, half 0) of an output pixel.

Behaviour:
- Reset: state IDLE, all counters 0. All outputs 0 except wr_ready, which is 1.
- States:
  - IDLE: if cfg_start, check the config.
    - Illegal (W==0, H==0, W>MAX_DIM or H>MAX_DIM): cfg_err pulses next cycle, stay IDLE.
    - Legal: go to RUN next cycle.
  - RUN: leave after the final issue slot.
  - DRAIN: 1 cycle, delivers the last sideband, then IDLE.
- Write path: wr_ready = (state==IDLE). imap_wen = wr_valid & wr_ready. imap_waddr and imap_wdata are a combinational pass-through of wr_addr and wr_data.
  - A write and cfg_start in the same IDLE cycle: the write is accepted and RUN begins next cycle.
- Mutual exclusion: imap_wen and imap_ren are never high together.
- Issue order, outermost to innermost: oy 0..H-1, ox 0..W-1, ky 0..2, kx 0..2, half 0..1.
  - One slot per RUN cycle with array_stall low.
  - array_stall high freezes all counters; imap_ren is 0 that cycle.
- Address arithmetic: iy = oy+ky-1, ix = ox+kx-1 (signed).
  - A slot is a pad if iy<0, iy>=H, ix<0 or ix>=W.
  - Non-pad slot: imap_ren=1, imap_raddr[11:0]=iy*W+ix, imap_raddr[12]=half, imap_raddr[31:13]=0.
  - Pad slot: imap_ren=0, imap_raddr=0.
- Sideband latency is exactly 1 cycle after the issue slot, for both pad and non-pad slots: dat_valid=1, dat_pad = pad flag, dat_first / dat_last per the slot.
  - Stall cycles produce no dat_valid.
  - A slot already issued is always delivered, even if array_stall rises.
- busy is high from the cycle after an accepted start through the final dat_valid cycle.
- done pulses the cycle after the final dat_valid; busy is 0 in that cycle.
- cfg_start while busy is ignored, with no error.
- rst asserted mid-run returns everything to its reset values immediately. No done pulse.

Optional Feature:
- IMAP_SCHED_PERF_EN defined: adds outputs perf_rd_cnt[31:0], perf_pad_cnt[31:0] and perf_stall_cnt[31:0].
  - Counted events: issued reads, pad slots, and RUN cycles with array_stall high.
  - Cleared on reset and on an accepted start; saturating.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package imap_pkg holds:
  - ARRAY_NUM=32, BLOCK_SIZE=56*56, MAX_DIM, PIX_W, DIM_W;
  - the state encoding (IDLE=0, RUN=1, DRAIN=2);
  - TAPS=9, HALVES=2.
- Sub-module imap_tap_cnt: nested oy/ox/ky/kx/half counter with an enable (not stalled). Outputs the indices plus first/last/final flags. The parent adds the pad/address logic, the FSM, the arbitration and the sideband pipeline register.

Test Plan:
- IDLE writes: 4 wr_valid beats to addr 0..3 -> imap_wen on each beat with data passed through unchanged, wr_ready=1, imap_ren=0.
- Small map run: W=H=3, no stall -> 162 dat_valid cycles, of which 98 have imap_ren and 64 are pads.
  - The first slot (oy=ox=ky=kx=0) is a pad.
  - The first read is tap ky=1,kx=1 at raddr 0x000, then 0x1000 for half 1.
  - done occurs 163 cycles after RUN entry.
- Stall: W=H=1 with array_stall high for 5 cycles mid-run -> exactly 18 dat_valid total (2 reads, 16 pads) and no slot lost or repeated. The run completes 5 cycles later than unstalled.
- Arbitration: wr_valid held high during RUN -> wr_ready=0 and imap_wen=0 until done. The write is accepted in the first IDLE cycle.
- Bad config: cfg_start with W=0, then with W=57 -> cfg_err pulse each time, busy stays 0, no imap_ren.
- Reset mid-run: assert rst at slot 50 of the W=H=3 run -> all outputs 0 and wr_ready=1 immediately, no done. A new start afterwards replays the sequence from slot 0.
